// File: rtl/btn_sw_pkg.sv
// Shared types for the button/switch front end: debounce state encoding
// and the switch bus width.
package btn_sw_pkg;

  localparam int SW_W = 4;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bundle of independent asynchronous pins.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      // stage 0 may go metastable; stage 1 gives it a full cycle to settle
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/btn_sw_sampler.sv
// Synchronizes and debounces the user button; on each accepted press emits a
// one-cycle select strobe together with a registered snapshot of the switches.
module btn_sw_sampler
  import btn_sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_btn,
  input  logic [SW_W-1:0] i_sw,
  output logic            o_sel,
  output logic [SW_W-1:0] o_a,
  output logic            o_btn_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W:0]    sync_q;
  logic             btn_s;
  logic [SW_W-1:0]  sw_s;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  sync_2ff #(
    .WIDTH(SW_W + 1)
  ) u_sync (
    .clk  (i_clk),
    .reset(i_reset),
    .d    ({i_btn, i_sw}),
    .q    (sync_q)
  );

  assign btn_s = sync_q[SW_W];
  assign sw_s  = sync_q[SW_W-1:0];

  // cnt holds how many consecutive samples have agreed with the pending level;
  // entering S_RISE/S_FALL already counts the first one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_LOW;
      cnt         <= '0;
      o_sel       <= 1'b0;
      o_a         <= '0;
      o_btn_level <= 1'b0;
    end else begin
      o_sel <= 1'b0;
      case (state)
        S_LOW: begin
          if (btn_s) begin
            state <= S_RISE;
            cnt   <= CNT_ONE;
          end
        end
        S_RISE: begin
          if (!btn_s) begin
            state <= S_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state       <= S_HIGH;
            cnt         <= '0;
            o_sel       <= 1'b1;
            o_a         <= sw_s;
            o_btn_level <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!btn_s) begin
            state <= S_FALL;
            cnt   <= CNT_ONE;
          end
        end
        S_FALL: begin
          if (btn_s) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state       <= S_LOW;
            cnt         <= '0;
            o_btn_level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_sw_sampler.sv
// Randomized and directed bench for btn_sw_sampler with a run-length
// reference model of the debounced button.
module tb_btn_sw_sampler;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_btn = 1'b0;
  logic [3:0] i_sw = 4'h0;
  logic       o_sel;
  logic [3:0] o_a;
  logic       o_btn_level;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // reference model: raw pins delayed two samples, level flips after D
  // consecutive delayed samples disagree with it
  logic [4:0] m_s1 = '0;
  logic [4:0] m_s2 = '0;
  logic       m_level = 1'b0;
  int         m_run = 0;
  logic       m_sel = 1'b0;
  logic [3:0] m_a = 4'h0;

  btn_sw_sampler #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_btn      (i_btn),
    .i_sw       (i_sw),
    .o_sel      (o_sel),
    .o_a        (o_a),
    .o_btn_level(o_btn_level)
  );

  always #5 clk = ~clk;

  // drive pins before one edge, advance the model across it, settle 1 time unit
  task automatic tick(input logic btn, input logic [3:0] sw, input logic rst);
    @(negedge clk);
    i_btn   = btn;
    i_sw    = sw;
    i_reset = rst;
    @(posedge clk);
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = 1'b0; m_run = 0; m_sel = 1'b0; m_a = 4'h0;
    end else begin
      m_sel = 1'b0;
      if (m_s2[4] != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = ~m_level;
          m_run = 0;
          if (m_level) begin
            m_sel = 1'b1;
            m_a   = m_s2[3:0];
          end
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = {btn, sw};
    end
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    tick(1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 4'h0, 1'b0);
      total++;
      if ({o_sel, o_a, o_btn_level} !== 6'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got sel=%b a=%h lvl=%b want all zero", i, o_sel, o_a, o_btn_level);
      end
    end
  endtask

  task automatic test_clean_press();
    int n = 0;
    int pos = -1;
    tick(1'b0, 4'hA, 1'b1);
    tick(1'b0, 4'hA, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 4'hA, 1'b0);
      total++;
      if ({o_sel, o_a, o_btn_level} !== {m_sel, m_a, m_level}) begin
        bad++;
        $display("FAIL clean_model i=%0d got %b/%h/%b want %b/%h/%b", i, o_sel, o_a, o_btn_level, m_sel, m_a, m_level);
      end
      if (o_sel === 1'b1) begin n++; pos = i; end
    end
    total++;
    if (n !== 1 || pos !== D + 1) begin
      bad++;
      $display("FAIL clean_strobe got count=%0d pos=%0d want count=1 pos=%0d", n, pos, D + 1);
    end
    total++;
    if (o_a !== 4'hA || o_btn_level !== 1'b1) begin
      bad++;
      $display("FAIL clean_hold got a=%h lvl=%b want a=a lvl=1", o_a, o_btn_level);
    end
  endtask

  task automatic test_bounce();
    logic pat [18] = '{1,1,0,1,1,1,0,0,1,1,1,1,1,1,1,1,1,1};
    int n = 0;
    int pos = -1;
    tick(1'b0, 4'h6, 1'b1);
    tick(1'b0, 4'h6, 1'b0);
    for (int i = 0; i < 18; i++) begin
      tick(pat[i], 4'h6, 1'b0);
      total++;
      if ({o_sel, o_a, o_btn_level} !== {m_sel, m_a, m_level}) begin
        bad++;
        $display("FAIL bounce_model i=%0d got %b/%h/%b want %b/%h/%b", i, o_sel, o_a, o_btn_level, m_sel, m_a, m_level);
      end
      if (o_sel === 1'b1) begin n++; pos = i; end
    end
    total++;
    if (n !== 1 || pos !== 8 + D + 1) begin
      bad++;
      $display("FAIL bounce_strobe got count=%0d pos=%0d want count=1 pos=%0d", n, pos, 8 + D + 1);
    end
  endtask

  task automatic test_held();
    int n = 0;
    tick(1'b0, 4'h9, 1'b1);
    tick(1'b0, 4'h9, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick(1'b1, (i < 50) ? 4'h9 : 4'h3, 1'b0);
      total++;
      if ({o_sel, o_a, o_btn_level} !== {m_sel, m_a, m_level}) begin
        bad++;
        $display("FAIL held_model i=%0d got %b/%h/%b want %b/%h/%b", i, o_sel, o_a, o_btn_level, m_sel, m_a, m_level);
      end
      if (o_sel === 1'b1) n++;
    end
    total++;
    if (n !== 1 || o_a !== 4'h9) begin
      bad++;
      $display("FAIL held_single got count=%0d a=%h want count=1 a=9", n, o_a);
    end
  endtask

  task automatic test_release_repress();
    int fall = -1;
    int n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 4'h3, 1'b0);
      total++;
      if ({o_sel, o_a, o_btn_level} !== {m_sel, m_a, m_level}) begin
        bad++;
        $display("FAIL release_model i=%0d got %b/%h/%b want %b/%h/%b", i, o_sel, o_a, o_btn_level, m_sel, m_a, m_level);
      end
      if (o_btn_level === 1'b0 && fall < 0) fall = i;
    end
    total++;
    if (fall !== D + 1 || o_a !== 4'h9) begin
      bad++;
      $display("FAIL release_fall got pos=%0d a=%h want pos=%0d a=9", fall, o_a, D + 1);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 4'h5, 1'b0);
      if (o_sel === 1'b1) n++;
    end
    total++;
    if (n !== 1 || o_a !== 4'h5 || o_btn_level !== 1'b1) begin
      bad++;
      $display("FAIL repress got count=%0d a=%h lvl=%b want count=1 a=5 lvl=1", n, o_a, o_btn_level);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int pos = -1;
    tick(1'b0, 4'hC, 1'b1);
    tick(1'b0, 4'hC, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 4'hC, 1'b0);
    tick(1'b1, 4'hC, 1'b1);
    total++;
    if ({o_sel, o_a, o_btn_level} !== 6'b0) begin
      bad++;
      $display("FAIL midreset_clear got sel=%b a=%h lvl=%b want all zero", o_sel, o_a, o_btn_level);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 4'hC, 1'b0);
      total++;
      if ({o_sel, o_a, o_btn_level} !== {m_sel, m_a, m_level}) begin
        bad++;
        $display("FAIL midreset_model i=%0d got %b/%h/%b want %b/%h/%b", i, o_sel, o_a, o_btn_level, m_sel, m_a, m_level);
      end
      if (o_sel === 1'b1) begin n++; pos = i; end
    end
    total++;
    if (n !== 1 || pos !== D + 1 || o_a !== 4'hC) begin
      bad++;
      $display("FAIL midreset_strobe got count=%0d pos=%0d a=%h want count=1 pos=%0d a=c", n, pos, o_a, D + 1);
    end
  endtask

  task automatic test_random();
    logic       btn = 1'b0;
    logic [3:0] sw = 4'h0;
    int         run = 0;
    int         last = -1000;
    int         n = 0;
    tick(1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        btn = ~btn;
        run = $urandom_range(1, 2 * D + 2);
      end
      run--;
      if ($urandom_range(0, 3) == 0) sw = 4'($urandom);
      tick(btn, sw, ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
      total++;
      if ({o_sel, o_a, o_btn_level} !== {m_sel, m_a, m_level}) begin
        bad++;
        $display("FAIL random_model i=%0d got %b/%h/%b want %b/%h/%b", i, o_sel, o_a, o_btn_level, m_sel, m_a, m_level);
      end
      if (i_reset) last = -1000;
      if (o_sel === 1'b1) begin
        n++;
        total++;
        if (i - last < 2 * D) begin
          bad++;
          $display("FAIL random_spacing i=%0d got gap=%0d want >=%0d", i, i - last, 2 * D);
        end
        last = i;
      end
    end
    total++;
    if (n == 0) begin
      bad++;
      $display("FAIL random_activity got strobes=0 want >0");
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_held();
    test_release_repress();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_sw_sampler.md
# btn_sw_sampler

- Front-end stage for the board's user inputs: a push-button plus four slide switches.
- Synchronizes the raw asynchronous pins and debounces the button.
- On each debounced press, emits a one-cycle select strobe and a registered 4-bit switch sample.
- Sits directly upstream of the 4-bit select/data mux stage and drives its select and data inputs with clean, fully registered values.

## Interface
- DEBOUNCE_CYCLES, default 250000 (10 ms at 25 MHz): consecutive stable synchronized samples required to accept a level change. Legal range ≥ 2.
- i_clk  input  1  system clock.
- i_reset  input  1  reset; one clock, synchronous, active-high.
- i_btn  input  1  raw button pin, active-high, asynchronous, bouncy.
- i_sw  input  4  raw switch pins, asynchronous.
- o_sel  output  1  one-cycle strobe on each accepted press (debounced rising edge).
- o_a  output  4  switch value sampled at the last accepted press; held otherwise.
- o_btn_level  output  1  debounced button level.

## Operation
- Synchronization:
  - i_btn and each i_sw bit pass through a 2-flop synchronizer, giving btn_s and sw_s.
  - Logic uses only btn_s and sw_s, never the raw pins.
- Debounce FSM, states S_LOW, S_RISE, S_HIGH, S_FALL, with counter cnt of width $clog2(DEBOUNCE_CYCLES).
  - S_LOW:
    - btn_s=1 → S_RISE, cnt=1.
    - Otherwise stay in S_LOW.
  - S_RISE:
    - btn_s=0 → S_LOW, cnt=0 (glitch rejected, no output change).
    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 → S_HIGH, cnt=0.
    - Otherwise cnt++.
  - S_HIGH:
    - btn_s=0 → S_FALL, cnt=1.
  - S_FALL:
    - btn_s=1 → S_HIGH, cnt=0.
    - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 → S_LOW, cnt=0.
    - Otherwise cnt++.
- Outputs, all registered:
  - On the S_RISE→S_HIGH edge: o_sel=1 for exactly one cycle, o_a←sw_s, o_btn_level←1.
  - On the S_FALL→S_LOW edge: o_btn_level←0. o_sel stays 0 and o_a is unchanged.
  - o_a changes only on an accepted press. Switch movement while idle or while held has no effect.
  - o_btn_level=1 in S_HIGH and S_FALL, 0 in S_LOW and S_RISE.
- Reset values: state S_LOW, cnt 0, o_sel 0, o_a 4'h0, o_btn_level 0, synchronizer flops 0.
  - Reset mid-count discards progress.
  - A button still held when reset releases must be re-qualified for DEBOUNCE_CYCLES samples and then produces one strobe.
- Every output is assigned on every clock path, so there are no latches and no combinational outputs.

## Timing
- Let raw i_btn rise before edge k and stay high. Then:
  - btn_s=1 after edge k+1.
  - S_RISE entered at edge k+2.
  - o_sel, o_a and o_btn_level update at edge k+DEBOUNCE_CYCLES+1.
  - o_sel deasserts at the next edge.
- Release acceptance: o_btn_level falls DEBOUNCE_CYCLES+1 edges after the first edge that samples raw i_btn low.
- o_a and the matching o_sel pulse become valid on the same edge, so downstream may consume both in the strobe cycle.
- Bounce rejection:
  - A btn_s high run shorter than DEBOUNCE_CYCLES produces no strobe.
  - A btn_s low run shorter than DEBOUNCE_CYCLES while held produces no second strobe.
- Minimum spacing between strobes is 2·DEBOUNCE_CYCLES cycles.

## Structure
- Package btn_sw_pkg holds:
  - the state enum (S_LOW, S_RISE, S_HIGH, S_FALL), 2-bit encoding;
  - localparam SW_W=4.
- Sub-module sync_2ff, parameter WIDTH, instantiated once with WIDTH=5 to cover the button and switches together.
- Top holds the FSM, counter and output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and a clean 1-cycle i_reset at start.
- Reset check:
  - Stimulus: reset, then observe 10 idle cycles.
  - Required: o_sel=0, o_a=0, o_btn_level=0 throughout.
- Clean press:
  - Stimulus: i_sw=4'hA; raise i_btn before edge k and hold.
  - Required: single o_sel pulse after edge k+5; o_a=4'hA from that edge; o_btn_level=1.
- Bounce:
  - Stimulus: toggle i_btn as high 2 cycles, low 1, high 3, low 2, then hold high.
  - Required: exactly one o_sel pulse, occurring after the final 4 consecutive high samples.
- Held button:
  - Stimulus: hold i_btn high for 100 cycles; change i_sw to 4'h3 mid-hold.
  - Required: one strobe only; o_a keeps its press-time value.
- Release and re-press:
  - Stimulus: release, then re-press with i_sw=4'h5.
  - Required: o_btn_level falls 5 edges after release is sampled; new strobe with o_a=4'h5.
- Reset mid-count:
  - Stimulus: assert i_reset while in S_RISE with i_btn held.
  - Required: outputs return to reset values; one strobe follows 4 qualifying samples after the synchronizer refills.
